pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined ripple-carry adder that generalises the 1-bit full adder to WIDTH bits split across STAGES register stages. It carries a valid/ready handshake on both sides and has a signed-overflow flag. It is the arithmetic core feeding the 74181-style ALU datapath, and it supports operand widths beyond 4 bits at a higher clock rate.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage adds CHUNK = WIDTH/STAGES bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- sub  input  1  subtract request; present only when PIPE_ADDER_SUB_EN is defined.
- in_valid  input  1  operands valid.
- in_ready  output  1  adder accepts operands this cycle.
- s  output  WIDTH  sum.
- c_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement signed overflow.
- out_valid  output  1  s, c_out and overflow are valid.
- out_ready  input  1  consumer accepts the result.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- advance = out_ready || !out_valid. All stages shift together when advance = 1; otherwise every stage holds.
- in_ready = advance (combinational). in_valid=0 during advance inserts a bubble (stage valid=0).
- Stage k (0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] of the delayed a and b, plus the carry registered by stage k-1. Stage 0 uses c_in.
  - Registers the chunk sum and the chunk carry.
  - Forwards the unused upper operand chunks and the already-computed lower sum chunks in delay registers.
- Final stage outputs:
  - s is the concatenation of all chunk sums.
  - c_out is the final carry.
  - overflow = carry into bit WIDTH-1 XOR c_out.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- Results leave in acceptance order. No reordering and no drop.
- Reset (async, any time):
  - All stage valid bits = 0 and all data registers = 0.
  - Outputs: s=0, c_out=0, overflow=0, out_valid=0.
  - in_ready=1 while rst_n is high and the pipe is empty.
  - In-flight operations are discarded.

## Timing
- Latency: STAGES cycles from the accepting edge to out_valid=1, with no stall.
- Throughput: one result per cycle while out_ready=1.
- Stall: if out_valid=1 and out_ready=0:
  - s, c_out and overflow stay stable.
  - in_ready=0 in the same cycle.
  - Upstream holds a, b, c_in and in_valid.
- Simultaneous in-transfer and out-transfer in one cycle is legal and required at full rate.
- out_ready may toggle every cycle. in_ready follows it combinationally: there is no skid buffer, so the combinational ready path is accepted.
- STAGES=1 degenerates to a single registered WIDTH-bit adder with 1-cycle latency.

## Configuration
- PIPE_ADDER_SUB_EN defined:
  - Adds the sub port, which travels down the pipe with its operands.
  - sub=1 computes a + ~b + 1; c_in is ignored for that operation.
  - c_out=1 means no borrow. overflow applies the same rule to a + ~b + 1.
- Not defined:
  - No sub port; the block adds only.
  - No extra registers.

## Structure
- pipe_adder_pkg holds:
  - Default WIDTH and STAGES localparams.
  - A function chunk_w(WIDTH, STAGES).
  - An elaboration check (WIDTH % STAGES == 0, STAGES >= 1), with $fatal on violation.
- One sub-module, pipe_adder_stage, instantiated STAGES times via generate:
  - One CHUNK-bit add with carry.
  - Its valid flop.
  - Hold-on-!advance logic.
- The top level holds the operand/sum delay lines and the handshake logic.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1, a=0xFFFF, b=0x0001, c_in=0 -> after 4 cycles: s=0x0000, c_out=1, overflow=0, out_valid=1 for exactly one cycle.
- a=0x7FFF, b=0x0001, c_in=0 -> s=0x8000, c_out=0, overflow=1. Also a=0x8000, b=0x8000 -> s=0x0000, c_out=1, overflow=1.
- 8 back-to-back random operations, in_valid=1 and out_ready=1 throughout -> 8 consecutive out_valid cycles starting at cycle 4, results in order, each matching a+b+c_in modulo 2^16.
- Result pending, out_ready=0 for 3 cycles while issuing new operands -> in_ready=0, s stable for all 3 cycles. After out_ready=1, every queued result emerges once and in order.
- rst_n pulsed low mid-stream with 3 operations in flight -> out_valid=0 immediately and all outputs 0. After release, no stale result ever appears, and the first new operation emerges 4 cycles after acceptance.
- With PIPE_ADDER_SUB_EN, sub=1, a=0x0005, b=0x0007, c_in=1 -> s=0xFFFE, c_out=0, overflow=0. A 2-bit exhaustive sweep (WIDTH=2, STAGES=2, all a/b/c_in, both values of sub) matches the reference model.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared defaults and elaboration helpers for the pipelined adder.
// The chunk width is WIDTH/STAGES; cfg_ok() rejects non-divisible configurations.
package pipe_adder_pkg;

  localparam int unsigned PIPE_ADDER_WIDTH  = 16;
  localparam int unsigned PIPE_ADDER_STAGES = 4;

  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    if (stages < 1) return 1'b0;
    return (width % stages) == 0;
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline stage: CHUNK-bit add with carry, registered sum/carry/valid,
// all held while advance is low. OVF_EN enables the signed-overflow flop.
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int unsigned CHUNK  = 4,
  parameter bit          OVF_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             valid_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             inv_b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_q,
  output logic             c_q,
  output logic             ovf_q,
  output logic             valid_q
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   full;
  logic             ovf_new;
  logic [CHUNK-1:0] sum_d;
  logic             c_d;
  logic             ovf_d;
  logic             valid_d;

  assign b_eff = inv_b_i ? ~b_i : b_i;
  assign full  = {1'b0, a_i} + {1'b0, b_eff} + {{CHUNK{1'b0}}, c_i};

  // Carry into the chunk MSB is recovered from the MSB sum bit and its operands.
  if (OVF_EN) begin : g_ovf
    assign ovf_new = (a_i[CHUNK-1] ^ b_eff[CHUNK-1] ^ full[CHUNK-1]) ^ full[CHUNK];
  end else begin : g_no_ovf
    assign ovf_new = 1'b0;
  end

  always_comb begin
    sum_d   = sum_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    if (advance) begin
      sum_d   = full[CHUNK-1:0];
      c_d     = full[CHUNK];
      ovf_d   = ovf_new;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit ripple-carry adder split across STAGES register stages
// with valid/ready handshake. Define PIPE_ADDER_SUB_EN to add the sub port.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = PIPE_ADDER_WIDTH,
  parameter int unsigned STAGES = PIPE_ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $fatal(1, "pipe_adder: WIDTH (%0d) must be a multiple of STAGES (%0d) and STAGES >= 1",
           WIDTH, STAGES);
  end

  logic              advance;
  logic              c_in_eff;
  logic              inv_in;
  logic [STAGES-1:0] stage_ovf;

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

`ifdef PIPE_ADDER_SUB_EN
  assign inv_in   = sub;
  assign c_in_eff = sub | c_in;
`else
  assign inv_in   = 1'b0;
  assign c_in_eff = c_in;
`endif

  // Only the final stage tracks overflow; earlier stages hold their flag at 0.
  assign overflow = |stage_ovf;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned OP_W = (STAGES - k) * CHUNK;

    // opa/opb: operand chunks k..STAGES-1 aligned with this stage's inputs.
    // res: sum chunks 0..k aligned with this stage's registered output.
    logic [OP_W-1:0]          opa;
    logic [OP_W-1:0]          opb;
    logic [(k+1)*CHUNK-1:0]   res;
    logic [CHUNK-1:0]         sum_q;
    logic                     c_i;
    logic                     c_q;
    logic                     v_i;
    logic                     valid_q;
    logic                     inv_b;

    if (k == 0) begin : g_head
      assign opa   = a;
      assign opb   = b;
      assign c_i   = c_in_eff;
      assign v_i   = in_valid;
      assign inv_b = inv_in;
      assign res   = sum_q;
    end else begin : g_body
      logic [OP_W-1:0]      opa_q, opa_d;
      logic [OP_W-1:0]      opb_q, opb_d;
      logic [k*CHUNK-1:0]   fwd_q, fwd_d;

      always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        fwd_d = fwd_q;
        if (advance) begin
          opa_d = g_stage[k-1].opa[OP_W+CHUNK-1:CHUNK];
          opb_d = g_stage[k-1].opb[OP_W+CHUNK-1:CHUNK];
          fwd_d = g_stage[k-1].res;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
          fwd_q <= '0;
        end else begin
          opa_q <= opa_d;
          opb_q <= opb_d;
          fwd_q <= fwd_d;
        end
      end

`ifdef PIPE_ADDER_SUB_EN
      logic sub_q, sub_d;

      always_comb begin
        sub_d = sub_q;
        if (advance) sub_d = g_stage[k-1].inv_b;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sub_q <= 1'b0;
        else        sub_q <= sub_d;
      end

      assign inv_b = sub_q;
`else
      assign inv_b = 1'b0;
`endif

      assign opa = opa_q;
      assign opb = opb_q;
      assign c_i = g_stage[k-1].c_q;
      assign v_i = g_stage[k-1].valid_q;
      assign res = {sum_q, fwd_q};
    end

    pipe_adder_stage #(
      .CHUNK  (CHUNK),
      .OVF_EN (k == STAGES - 1)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (advance),
      .valid_i (v_i),
      .a_i     (opa[CHUNK-1:0]),
      .b_i     (opb[CHUNK-1:0]),
      .inv_b_i (inv_b),
      .c_i     (c_i),
      .sum_q   (sum_q),
      .c_q     (c_q),
      .ovf_q   (stage_ovf[k]),
      .valid_q (valid_q)
    );

    if (k == STAGES - 1) begin : g_tail
      assign s         = res;
      assign c_out     = c_q;
      assign out_valid = valid_q;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: 16-bit/4-stage main instance plus a
// 2-bit/2-stage instance for an exhaustive sweep.
module tb_pipe_adder;

`ifdef PIPE_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif
  localparam int STAGES = 4;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } sb_ent_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic        c_in;
  logic        in_valid, in_ready;
  logic [15:0] s;
  logic        c_out, overflow, out_valid, out_ready;
`ifdef PIPE_ADDER_SUB_EN
  logic        sub;
  logic        sub2;
`endif

  logic [1:0]  a2, b2, s2;
  logic        c2_in, iv2, ir2, co2, ov2, ovl2, or2;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          bp_en = 1'b0;
  sb_ent_t     sb[$];
  logic [31:0] sb2[$];

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef PIPE_ADDER_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .c_out     (c_out),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  pipe_adder #(.WIDTH(2), .STAGES(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a2),
    .b         (b2),
    .c_in      (c2_in),
`ifdef PIPE_ADDER_SUB_EN
    .sub       (sub2),
`endif
    .in_valid  (iv2),
    .in_ready  (ir2),
    .s         (s2),
    .c_out     (co2),
    .overflow  (ov2),
    .out_valid (ovl2),
    .out_ready (or2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {overflow, carry, sum} for a w-bit add, overflow by sign comparison.
  function automatic logic [31:0] ref_sum(input int unsigned w, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci, input logic sb_op);
    logic [63:0] mask, xx, bb, full, sres;
    logic        co, ovf;
    mask = (64'd1 << w) - 64'd1;
    xx   = {32'd0, x} & mask;
    bb   = sb_op ? (~{32'd0, y}) & mask : {32'd0, y} & mask;
    full = xx + bb + {63'd0, sb_op ? 1'b1 : ci};
    sres = full & mask;
    co   = full[w];
    ovf  = (xx[w-1] == bb[w-1]) && (sres[w-1] != xx[w-1]);
    return 32'(sres) | (32'(co) << w) | (32'(ovf) << (w + 1));
  endfunction

  task automatic drive_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input logic ts);
    bit      done = 1'b0;
    sb_ent_t ent;
    a = ta;
    b = tb;
    c_in = tc;
`ifdef PIPE_ADDER_SUB_EN
    sub = ts;
`endif
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ent.exp = ref_sum(16, {16'd0, ta}, {16'd0, tb}, tc, ts);
        ent.acc = cyc + 1;
        sb.push_back(ent);
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    if (!done) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb.size(), 32'd0);
  endtask

  // Output monitor: pops the scoreboard on each out-transfer, checks stall stability.
  logic [31:0] held;
  bit          stall_prev = 1'b0;
  always @(negedge clk) begin
    sb_ent_t     ent;
    logic [31:0] cur;
    cur = {13'd0, out_valid, overflow, c_out, s};
    if (rst_n && stall_prev) check("stall_hold", cur, held);
    stall_prev = rst_n && out_valid && !out_ready;
    held = cur;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        ent = sb.pop_front();
        check("result", {14'd0, overflow, c_out, s}, ent.exp);
        if (chk_lat) check("latency", cyc - ent.acc + 1, STAGES);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e2;
    if (rst_n && ovl2 && or2) begin
      if (sb2.size() == 0) begin
        check("unexpected_out2", {31'd0, ovl2}, 32'd0);
      end else begin
        e2 = sb2.pop_front();
        check("sweep2", {28'd0, ov2, co2, s2}, e2);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b1;
    a = '0; b = '0; c_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    sub = 1'b0; sub2 = 1'b0;
`endif
    a2 = '0; b2 = '0; c2_in = 1'b0; iv2 = 1'b0; or2 = 1'b1;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_c_out", {31'd0, c_out}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op: wraps to zero with carry, one-cycle out_valid pulse.
    chk_lat = 1'b1;
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    check("single_pulse", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Signed-overflow and carry boundaries, back to back.
    drive_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drive_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    drive_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    drive_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    drive_op(16'h1234, 16'h4321, 1'b1, 1'b0);
`ifdef PIPE_ADDER_SUB_EN
    drive_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    drive_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    drive_op(16'h1234, 16'h1234, 1'b0, 1'b1);
`endif
    drain();

    // 8 random operations at full rate.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      drive_op(ra[15:0], rb[15:0], ra[16], 1'b0);
    end
    drain();

    // Stall: result held for 3 cycles with new operands waiting.
    chk_lat = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_op(16'h1111 * 16'(i + 1), 16'h0F0F, 1'b0, 1'b0);
    a = 16'hABCD; b = 16'h1234; c_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drive_op(16'hABCD, 16'h1234, 1'b1, 1'b0);
    drain();

    // Random backpressure with random operands.
    bp_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      drive_op(ra[15:0], rb[15:0], ra[16], HAS_SUB ? ra[17] : 1'b0);
      if (rb[16]) idle(1);
    end
    in_valid = 1'b0;
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Reset with three operations in flight.
    chk_lat = 1'b1;
    drive_op(16'h1357, 16'h2468, 1'b1, 1'b0);
    drive_op(16'hF00F, 16'h0FF0, 1'b0, 1'b0);
    drive_op(16'h4444, 16'h5555, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_outputs", {14'd0, overflow, c_out, s}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    drive_op(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    drain();

    // Exhaustive 2-bit sweep on the 2-stage instance.
    for (int sv = 0; sv < (HAS_SUB ? 2 : 1); sv++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          for (int ci = 0; ci < 2; ci++) begin
            a2 = 2'(x);
            b2 = 2'(y);
            c2_in = 1'(ci);
`ifdef PIPE_ADDER_SUB_EN
            sub2 = 1'(sv);
`endif
            iv2 = 1'b1;
            @(negedge clk);
            check("ready2", {31'd0, ir2}, 32'd1);
            sb2.push_back(ref_sum(2, 32'(x), 32'(y), 1'(ci), 1'(sv)));
            @(posedge clk);
            #1;
          end
        end
      end
    end
    iv2 = 1'b0;
    for (int i = 0; i < 20 && sb2.size() != 0; i++) @(posedge clk);
    #1;
    check("drain2", sb2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
